// File: rtl/fir_coeff_bank_ctrl_if.sv
// Host coefficient-RAM write/readback bus plus the MAC parallel tap-read port.
// master = host/MAC side, slave = coefficient bank controller.
interface fir_coeff_bank_ctrl_if #(
  parameter int DW       = 16,
  parameter int AW       = 6,
  parameter int NUM_BANK = 4
);
  logic                   iCsnRam;
  logic                   iWrnRam;
  logic [AW-1:0]          iAddrRam;
  logic [DW-1:0]          iWrDtRam;
  logic [DW-1:0]          oRdDtRam;
  logic                   iRdEnCoeff;
  logic [3:0]             iRdAddrCoeff;
  logic [NUM_BANK*DW-1:0] oRdDtCoeff;
  logic                   oRdValid;

  modport master (
    output iCsnRam, iWrnRam, iAddrRam, iWrDtRam, iRdEnCoeff, iRdAddrCoeff,
    input  oRdDtRam, oRdDtCoeff, oRdValid
  );

  modport slave (
    input  iCsnRam, iWrnRam, iAddrRam, iWrDtRam, iRdEnCoeff, iRdAddrCoeff,
    output oRdDtRam, oRdDtCoeff, oRdValid
  );
endinterface

// File: rtl/fir_coeff_bank_ctrl.sv
// FIR coefficient bank controller: 4 banks x 10 taps, host write decode, parallel MAC reads.
// Optional host readback port enabled by `define COEFF_READBACK_EN.
module fir_coeff_bank_ctrl #(
   parameter int NUM_BANK = 4,
   parameter int NUM_TAP  = 10,
   parameter int DW       = 16,
   parameter int AW       = 6
) (
   input  logic                 iClk12M,
   input  logic                 iRst,
   input  logic                 iCoeffUpdateFlag,
   fir_coeff_bank_ctrl_if.slave bus,
   output logic                 oCoeffReady,
   output logic                 oWrErr,
   output logic [5:0]           oWrCnt
);

   typedef enum logic {ST_RUN, ST_UPDATE} state_t;

   state_t                           state;
   logic [DW-1:0]                    coeff [NUM_BANK][NUM_TAP];
   logic [NUM_BANK-1:0][NUM_TAP-1:0] mask;

   logic [1:0]             wrBank;
   logic [3:0]             wrTap;
   logic                   wrTapOk;
   logic                   wrStrobe;
   logic                   rdTapOk;
   logic [NUM_BANK*DW-1:0] rdWord;

   assign wrBank   = bus.iAddrRam[AW-1:AW-2];
   assign wrTap    = bus.iAddrRam[AW-3:0];
   assign wrTapOk  = wrTap < 4'(NUM_TAP);
   assign wrStrobe = !bus.iCsnRam && !bus.iWrnRam;
   assign rdTapOk  = bus.iRdAddrCoeff < 4'(NUM_TAP);

   always_comb begin
      rdWord = '0;
      for (int unsigned b = 0; b < NUM_BANK; b++)
         rdWord[b*DW +: DW] = coeff[b][bus.iRdAddrCoeff];
   end

   function automatic logic [5:0] popCount(input logic [NUM_BANK-1:0][NUM_TAP-1:0] m);
      popCount = '0;
      for (int unsigned b = 0; b < NUM_BANK; b++)
         for (int unsigned t = 0; t < NUM_TAP; t++)
            popCount = popCount + 6'(m[b][t]);
   endfunction

   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         state          <= ST_RUN;
         mask           <= '0;
         oWrErr         <= 1'b0;
         oWrCnt         <= '0;
         oCoeffReady    <= 1'b0;
         bus.oRdValid   <= 1'b0;
         bus.oRdDtCoeff <= '0;
         for (int unsigned b = 0; b < NUM_BANK; b++)
            for (int unsigned t = 0; t < NUM_TAP; t++)
               coeff[b][t] <= '0;
      end else begin
         case (state)
            ST_RUN:
               if (iCoeffUpdateFlag) begin
                  state  <= ST_UPDATE;
                  mask   <= '0;
                  oWrErr <= 1'b0;
               end
            ST_UPDATE:
               if (!iCoeffUpdateFlag) state <= ST_RUN;
         endcase

         // Placed after the update-entry clear so a strobe on the entry edge still flags.
         if (wrStrobe) begin
            if (state == ST_UPDATE && wrTapOk) begin
               coeff[wrBank][wrTap] <= bus.iWrDtRam;
               mask[wrBank][wrTap]  <= 1'b1;
            end else begin
               oWrErr <= 1'b1;
            end
         end

         oWrCnt      <= popCount(mask);
         oCoeffReady <= (state == ST_RUN) && (&mask);

         if (state == ST_UPDATE) begin
            bus.oRdValid   <= 1'b0;
            bus.oRdDtCoeff <= '0;
         end else if (bus.iRdEnCoeff) begin
            bus.oRdValid   <= 1'b1;
            bus.oRdDtCoeff <= rdTapOk ? rdWord : '0;
         end else begin
            bus.oRdValid   <= 1'b0;
         end
      end
   end

`ifdef COEFF_READBACK_EN
   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst)
         bus.oRdDtRam <= '0;
      else if (!bus.iCsnRam && bus.iWrnRam)
         bus.oRdDtRam <= wrTapOk ? coeff[wrBank][wrTap] : '0;
   end
`else
   assign bus.oRdDtRam = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// Directed self-checking bench for fir_coeff_bank_ctrl.
module tb_fir_coeff_bank_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       flag;
   logic       coeffReady;
   logic       wrErr;
   logic [5:0] wrCnt;

   int nChecks = 0;
   int nErrors = 0;

   fir_coeff_bank_ctrl_if bus ();

   fir_coeff_bank_ctrl dut (
      .iClk12M          (clk),
      .iRst             (rst),
      .iCoeffUpdateFlag (flag),
      .bus              (bus.slave),
      .oCoeffReady      (coeffReady),
      .oWrErr           (wrErr),
      .oWrCnt           (wrCnt)
   );

   always #5 clk = ~clk;

   // Kaiser-shaped table, coefficient i lands at bank i/10, tap i%10
   logic [15:0] tbl [40] = '{
      16'hFFF3, 16'hFFE1, 16'h0000, 16'h004A, 16'h00B2, 16'h0123, 16'h0237, 16'h03A0, 16'h0511, 16'h0650,
      16'h0C00, 16'h1400, 16'h2200, 16'h3000, 16'h3F00, 16'h4B00, 16'h5555, 16'h5E00, 16'h6400, 16'h6600,
      16'h6400, 16'h5E00, 16'h4B00, 16'h3F00, 16'h3000, 16'h0500, 16'h0237, 16'h0123, 16'hFF80, 16'hFF10,
      16'hFEE0, 16'hFF00, 16'hFF60, 16'hFFC0, 16'hFFE8, 16'h0010, 16'h0000, 16'h0008, 16'hFFFC, 16'h0001
   };
   logic [15:0] mdl [40];

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [63:0] expWord(input int tap);
      return {mdl[30+tap], mdl[20+tap], mdl[10+tap], mdl[tap]};
   endfunction

   task automatic hostWrite(input logic [5:0] addr, input logic [15:0] data, input int hold = 1);
      bus.iCsnRam  = 1'b0;
      bus.iWrnRam  = 1'b0;
      bus.iAddrRam = addr;
      bus.iWrDtRam = data;
      tick(hold);
      bus.iCsnRam  = 1'b1;
      bus.iWrnRam  = 1'b1;
   endtask

   task automatic macRead(input logic [3:0] tap);
      bus.iRdEnCoeff   = 1'b1;
      bus.iRdAddrCoeff = tap;
      tick();
      bus.iRdEnCoeff   = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, "_valid"}, 64'(bus.oRdValid), 64'h0);
      checkVal({tag, "_data"},  bus.oRdDtCoeff,    64'h0);
      checkVal({tag, "_ready"}, 64'(coeffReady),   64'h0);
      checkVal({tag, "_err"},   64'(wrErr),        64'h0);
      checkVal({tag, "_cnt"},   64'(wrCnt),        64'h0);
      checkVal({tag, "_rdram"}, 64'(bus.oRdDtRam), 64'h0);
   endtask

   initial begin
      int a;
      rst = 1'b1; flag = 1'b0;
      bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1; bus.iAddrRam = '0; bus.iWrDtRam = '0;
      bus.iRdEnCoeff = 1'b0; bus.iRdAddrCoeff = '0;
      for (int i = 0; i < 40; i++) mdl[i] = tbl[i];
      #2;
      checkAllZero("rst");
      tick(2);
      rst = 1'b0;
      tick();
      checkAllZero("post_rst");

      // Full load
      flag = 1'b1;
      tick();
      for (int i = 0; i < 40; i++) begin
         a = ((i / 10) << 4) | (i % 10);
         hostWrite(6'(a), tbl[i]);
      end
      flag = 1'b0;
      tick(3);
      checkVal("load_cnt",   64'(wrCnt),      64'd40);
      checkVal("load_ready", 64'(coeffReady), 64'h1);
      checkVal("load_err",   64'(wrErr),      64'h0);

      // Tap 6 read, literal expectation
      macRead(4'd6);
      checkVal("rd6_valid", 64'(bus.oRdValid), 64'h1);
      checkVal("rd6_data",  bus.oRdDtCoeff,    64'h0000_0237_5555_0237);
      tick();
      checkVal("rd6_idle_valid", 64'(bus.oRdValid), 64'h0);

      // Back-to-back reads, then out-of-range tap
      bus.iRdEnCoeff = 1'b1;
      bus.iRdAddrCoeff = 4'd0;
      tick();
      checkVal("b2b0_data", bus.oRdDtCoeff, expWord(0));
      bus.iRdAddrCoeff = 4'd9;
      tick();
      checkVal("b2b9_valid", 64'(bus.oRdValid), 64'h1);
      checkVal("b2b9_data",  bus.oRdDtCoeff,    expWord(9));
      bus.iRdAddrCoeff = 4'd10;
      tick();
      bus.iRdEnCoeff = 1'b0;
      checkVal("rd10_valid", 64'(bus.oRdValid), 64'h1);
      checkVal("rd10_data",  bus.oRdDtCoeff,    64'h0);

      // Host readback
      bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b1; bus.iAddrRam = 6'h16;
      tick();
`ifdef COEFF_READBACK_EN
      checkVal("rdram_16", 64'(bus.oRdDtRam), 64'h5555);
      bus.iAddrRam = 6'h0B;
      tick();
      checkVal("rdram_bad", 64'(bus.oRdDtRam), 64'h0);
`else
      checkVal("rdram_off", 64'(bus.oRdDtRam), 64'h0);
      checkVal("rdram_noerr", 64'(wrErr), 64'h0);
`endif
      bus.iCsnRam = 1'b1;

      // Protocol errors
      flag = 1'b1;
      tick();
      hostWrite(6'h0C, 16'hDEAD);
      checkVal("bad_tap_err", 64'(wrErr), 64'h1);
      flag = 1'b0;
      tick(2);
      hostWrite(6'h00, 16'hBEEF);
      tick(2);
      checkVal("run_wr_err", 64'(wrErr), 64'h1);
      checkVal("err_cnt",    64'(wrCnt), 64'd0);
      macRead(4'd0);
      checkVal("err_data_kept", bus.oRdDtCoeff, expWord(0));
      flag = 1'b1;
      tick();
      checkVal("reentry_clr", 64'(wrErr), 64'h0);
      flag = 1'b0;
      tick(2);

      // Flag rise coincident with a strobe counts as a run-mode write
      flag = 1'b1;
      hostWrite(6'h00, 16'h1111);
      checkVal("edge_wr_err", 64'(wrErr), 64'h1);

      // Partial update: skip location 0, change 1/0, hold one strobe 3 cycles
      for (int i = 1; i < 40; i++) begin
         a = ((i / 10) << 4) | (i % 10);
         if (i == 10) begin
            hostWrite(6'(a), 16'h8001, 3);
            mdl[10] = 16'h8001;
         end else begin
            hostWrite(6'(a), tbl[i]);
         end
      end
      tick();
      checkVal("upd_cnt", 64'(wrCnt), 64'd39);
      macRead(4'd2);
      checkVal("upd_rd_valid", 64'(bus.oRdValid), 64'h0);
      checkVal("upd_rd_data",  bus.oRdDtCoeff,    64'h0);
      flag = 1'b0;
      tick(3);
      checkVal("part_cnt",   64'(wrCnt),      64'd39);
      checkVal("part_ready", 64'(coeffReady), 64'h0);
      checkVal("part_err",   64'(wrErr),      64'h1);
      macRead(4'd0);
      checkVal("part_rd0", bus.oRdDtCoeff, expWord(0));

      // Reset mid-run wipes contents
      rst = 1'b1;
      #2;
      checkVal("rst2_cnt", 64'(wrCnt), 64'd0);
      checkVal("rst2_err", 64'(wrErr), 64'h0);
      tick();
      rst = 1'b0;
      tick();
      macRead(4'd6);
      checkVal("rst2_rd_valid", 64'(bus.oRdValid), 64'h1);
      checkVal("rst2_rd_data",  bus.oRdDtCoeff,    64'h0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
